fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Parametrised instruction-fetch stage for the pipelined core.
- Owns the PC and EPC registers.
- Issues one outstanding request at a time to a variable-latency instruction memory.
- Presents fetched instructions to decode through a valid/stall output register.
- Handles halt, exception entry, return-from-exception (RTI) and branch redirect, including squashing an in-flight fetch after a redirect.

Parameters:
- DATA_W, 16, width of PC, EPC, addresses and instruction words.
- RESET_VEC, 16'h0000, PC value loaded on reset.
- EXC_VEC, 16'h0002, exception handler entry address.
- PC_INC, 2, byte increment between sequential instructions.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- halt  in  1  halt request from decode; sticky until reset.
- exception  in  1  one-cycle exception pulse from execute.
- exc_pc  in  DATA_W  PC to save into EPC on exception.
- rti  in  1  one-cycle return-from-exception pulse.
- redirect  in  1  one-cycle branch/jump taken.
- redirect_pc  in  DATA_W  branch target.
- stall  in  1  decode cannot accept; hold output register.
- imem_req  out  1  memory request valid.
- imem_addr  out  DATA_W  request address (= pc).
- imem_rdy  in  1  memory accepts request this cycle.
- imem_valid  in  1  read data valid (in order, ≥1 cycle after acceptance).
- imem_data  in  DATA_W  read data.
- if_valid  out  1  output register holds a live instruction.
- if_instr  out  DATA_W  instruction.
- if_pc  out  DATA_W  address of if_instr.
- if_inc_pc  out  DATA_W  if_pc + PC_INC.
- epc  out  DATA_W  saved exception PC.
- halted  out  1  unit is in HALT.

Behaviour:
- Reset (async assert, sync deassert use): pc=RESET_VEC, epc=0, state=ISSUE, squash=0, if_valid=0, if_instr=0, if_pc=0, if_inc_pc=0, imem_req=0, halted=0.
- States:
  - ISSUE: imem_req=1 when output register is free (!if_valid or !stall) and no control event is pending. On imem_rdy, go to WAIT and record the request PC.
  - WAIT: imem_req=0. On imem_valid:
    - if squash=0 and the output register is free: load if_instr/if_pc/if_inc_pc, set if_valid=1, pc += PC_INC, go to ISSUE.
    - if squash=1: drop the data, clear squash, go to ISSUE.
  - HALT: imem_req=0, halted=1, if_valid=0. Only reset exits.
- The output register may not be overwritten while if_valid=1 and stall=1; the data return must never be lost. The unit holds the request in ISSUE until the register frees; only one request is ever outstanding.
- if_valid drops to 0 the cycle after decode consumes (stall=0) unless a new instruction loads in the same cycle.
- Control event priority, same cycle, highest first: halt > exception > rti > redirect.
  - halt: go to HALT next cycle; the in-flight response is ignored.
  - exception: epc <= exc_pc; pc <= EXC_VEC.
  - rti: pc <= epc (the value before this edge).
  - redirect: pc <= redirect_pc.
- For exception, rti and redirect:
  - clear if_valid next cycle, even if stall=1;
  - if in WAIT, set squash=1;
  - if in ISSUE with imem_rdy high that cycle, suppress the request (imem_req forced 0).
- A control event arriving in the same cycle as imem_valid in WAIT discards that data and returns to ISSUE with squash=0.
- PC arithmetic is DATA_W-bit modulo: 16'hFFFE + 2 wraps to 16'h0000 with no flag.
- Reset mid-WAIT: any later imem_valid is ignored until the unit has issued a new request.

Decomposition:
- Shared package core_pkg: state enum (ISSUE, WAIT, HALT) and the RESET_VEC/EXC_VEC defaults as constants.
- One sub-module, fetch_out_reg: the valid/stall output register (load, hold, flush).
- The PC incrementer is the existing cla16 adder instantiated at DATA_W.

Test Plan:
1. Reset, memory with 1-cycle latency, imem_rdy=1, stall=0 → requests at 0x0000, 0x0002, 0x0004; if_pc follows with if_inc_pc = if_pc+2; if_valid steady at one instruction per two cycles.
2. stall=1 for 5 cycles while if_valid=1 with instr 0x1234 → if_instr holds 0x1234; no second request is accepted while full; the stream resumes in order on release.
3. Request to 0x0010 outstanding with 3-cycle latency, redirect to 0x0100 in cycle 1 → returning data is discarded, if_valid stays 0, next imem_addr=0x0100.
4. exception with exc_pc=0x0044, then rti 10 cycles later → epc=0x0044, a fetch at 0x0002, then a fetch at 0x0044; exception+redirect in the same cycle → pc=0x0002.
5. halt with a request outstanding → halted=1 next cycle, imem_req stays 0, if_valid=0; asserting rst_n low mid-cycle clears immediately and restarts at 0x0000.
6. pc=0xFFFE sequential fetch → next imem_addr=0x0000, if_inc_pc=0x0000.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: fetch FSM state encoding and default vectors.
package core_pkg;

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_t;

  localparam logic [15:0] RESET_VEC_DEF = 16'h0000;
  localparam logic [15:0] EXC_VEC_DEF   = 16'h0002;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus. The fetch unit is the master.
interface fetch_unit_if #(
  parameter int DATA_W = 16
);
  logic              req;
  logic [DATA_W-1:0] addr;
  logic              rdy;
  logic              valid;
  logic [DATA_W-1:0] data;

  modport master (output req, addr, input rdy, valid, data);
  modport slave  (input req, addr, output rdy, valid, data);
endinterface

// File: rtl/cla16.sv
// Parametrisable carry-lookahead adder (no carry out; PC arithmetic wraps).
module cla16 #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum
);
  logic [W-1:0] g_bit;
  logic [W-1:0] p_bit;
  logic [W-1:0] carry;

  assign carry[0] = cin;

  // Per-bit generate/propagate; the carry recurrence flattens into lookahead terms.
  for (genvar gi = 0; gi < W; gi++) begin : g_bits
    assign g_bit[gi] = a[gi] & b[gi];
    assign p_bit[gi] = a[gi] ^ b[gi];
    assign sum[gi]   = p_bit[gi] ^ carry[gi];
    if (gi < W - 1) begin : g_carry
      assign carry[gi+1] = g_bit[gi] | (p_bit[gi] & carry[gi]);
    end
  end
endmodule

// File: rtl/fetch_out_reg.sv
// Valid/stall output register between fetch and decode: load, hold, flush.
module fetch_out_reg #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              flush,
  input  logic              stall,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_inc_pc,
  output logic              valid,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] inc_pc
);
  // Flush wins over load; a consumed entry (stall low) empties unless refilled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      instr  <= '0;
      pc     <= '0;
      inc_pc <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid  <= 1'b1;
      instr  <= in_instr;
      pc     <= in_pc;
      inc_pc <= in_inc_pc;
    end else if (!stall) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC/EPC, one outstanding imem request,
// squashes in-flight responses after control redirects.
module fetch_unit
  import core_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter logic [DATA_W-1:0] RESET_VEC = DATA_W'(RESET_VEC_DEF),
  parameter logic [DATA_W-1:0] EXC_VEC   = DATA_W'(EXC_VEC_DEF),
  parameter int                PC_INC    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt,
  input  logic              exception,
  input  logic [DATA_W-1:0] exc_pc,
  input  logic              rti,
  input  logic              redirect,
  input  logic [DATA_W-1:0] redirect_pc,
  input  logic              stall,
  fetch_unit_if.master      imem,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [DATA_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_inc_pc,
  output logic [DATA_W-1:0] epc,
  output logic              halted
);
  fetch_state_t      state_reg;
  logic [DATA_W-1:0] pc_reg;
  logic [DATA_W-1:0] epc_reg;
  logic [DATA_W-1:0] req_pc_reg;
  logic              squash_reg;

  logic [DATA_W-1:0] pc_inc;
  logic [DATA_W-1:0] event_pc;
  logic              ctrl_evt;
  logic              any_evt;
  logic              out_free;
  logic              req_accept;
  logic              load;
  logic              flush;

  assign ctrl_evt   = exception | rti | redirect;
  assign any_evt    = halt | ctrl_evt;
  assign out_free   = !if_valid || !stall;
  assign imem.req   = rst_n && (state_reg == S_ISSUE) && out_free && !any_evt;
  assign imem.addr  = pc_reg;
  assign req_accept = imem.req && imem.rdy;
  assign epc        = epc_reg;
  assign halted     = (state_reg == S_HALT);

  // The output register is always empty in WAIT: a request is only issued when
  // the register is empty or being consumed, and nothing else loads it.
  assign load  = (state_reg == S_WAIT) && imem.valid && !squash_reg && !any_evt;
  assign flush = any_evt || (state_reg == S_HALT);

  cla16 #(.W(DATA_W)) u_pc_add (
    .a   (req_pc_reg),
    .b   (DATA_W'(PC_INC)),
    .cin (1'b0),
    .sum (pc_inc)
  );

  // Redirect target by priority: exception > rti > branch.
  always_comb begin
    event_pc = redirect_pc;
    if (exception)
      event_pc = EXC_VEC;
    else if (rti)
      event_pc = epc_reg;
  end

  // Fetch FSM: PC/EPC updates, request tracking and stale-response squash.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_ISSUE;
      pc_reg     <= RESET_VEC;
      epc_reg    <= '0;
      req_pc_reg <= '0;
      squash_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_HALT: state_reg <= S_HALT;
        default: begin
          if (halt) begin
            state_reg  <= S_HALT;
            squash_reg <= 1'b0;
          end else if (ctrl_evt) begin
            pc_reg <= event_pc;
            if (exception)
              epc_reg <= exc_pc;
            if (state_reg == S_WAIT) begin
              if (imem.valid) begin
                state_reg  <= S_ISSUE;
                squash_reg <= 1'b0;
              end else begin
                squash_reg <= 1'b1;
              end
            end
          end else if (state_reg == S_ISSUE) begin
            if (req_accept) begin
              state_reg  <= S_WAIT;
              req_pc_reg <= pc_reg;
            end
          end else if (imem.valid) begin
            state_reg  <= S_ISSUE;
            squash_reg <= 1'b0;
            if (!squash_reg)
              pc_reg <= pc_inc;
          end
        end
      endcase
    end
  end

  fetch_out_reg #(.DATA_W(DATA_W)) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .flush     (flush),
    .stall     (stall),
    .in_instr  (imem.data),
    .in_pc     (req_pc_reg),
    .in_inc_pc (pc_inc),
    .valid     (if_valid),
    .instr     (if_instr),
    .pc        (if_pc),
    .inc_pc    (if_inc_pc)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table for streaming/stall/redirect,
// hand sequences for squash, exception/rti, halt/async reset and PC wrap.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt, exception, rti, redirect, stall;
  logic [15:0] exc_pc, redirect_pc;
  logic        if_valid, halted;
  logic [15:0] if_instr, if_pc, if_inc_pc, epc;

  int checks = 0;
  int failures = 0;
  int lat = 1;
  int ovl_count = 0;

  fetch_unit_if #(.DATA_W(16)) imem_bus ();

  fetch_unit #(.DATA_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .halt        (halt),
    .exception   (exception),
    .exc_pc      (exc_pc),
    .rti         (rti),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .imem        (imem_bus),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_inc_pc   (if_inc_pc),
    .epc         (epc),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // Memory model: data = addr + 0x1230, response valid 'lat' cycles after accept.
  logic        pend;
  int          cnt;
  logic [15:0] paddr;
  always @(posedge clk) begin
    if (!rst_n) begin
      pend <= 1'b0;
      cnt <= 0;
      paddr <= '0;
      imem_bus.valid <= 1'b0;
      imem_bus.data <= '0;
    end else begin
      imem_bus.valid <= 1'b0;
      if (pend) begin
        if (cnt <= 1) begin
          imem_bus.valid <= 1'b1;
          imem_bus.data <= paddr + 16'h1230;
          pend <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
      if (imem_bus.req && imem_bus.rdy) begin
        if (pend) ovl_count <= ovl_count + 1;
        $display("imem accept addr=%h lat=%0d", imem_bus.addr, lat);
        if (lat <= 1) begin
          imem_bus.valid <= 1'b1;
          imem_bus.data <= imem_bus.addr + 16'h1230;
        end else begin
          pend <= 1'b1;
          cnt <= lat - 1;
          paddr <= imem_bus.addr;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    halt = 0; exception = 0; rti = 0; redirect = 0; stall = 0;
    exc_pc = '0; redirect_pc = '0;
  endtask

  // Leaves the bench at a negedge with reset released (cycle c0).
  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic        stall;
    logic        redir;
    logic [15:0] rpc;
    logic        exp_req;
    logic [15:0] exp_addr;
    logic        exp_valid;
    logic [15:0] exp_pc;
    logic [15:0] exp_instr;
  } vec_t;

  vec_t vecs[18];

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    imem_bus.rdy = 1'b1;
    rst_n = 0;
    clear_inputs();

    // stall redir rpc      req addr      valid pc        instr
    vecs[0]  = '{0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000};
    vecs[1]  = '{0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000};
    vecs[2]  = '{0, 0, 16'h0000, 1, 16'h0002, 1, 16'h0000, 16'h1230};
    vecs[3]  = '{0, 0, 16'h0000, 0, 16'h0002, 0, 16'h0000, 16'h0000};
    vecs[4]  = '{0, 0, 16'h0000, 1, 16'h0004, 1, 16'h0002, 16'h1232};
    vecs[5]  = '{0, 0, 16'h0000, 0, 16'h0004, 0, 16'h0000, 16'h0000};
    vecs[6]  = '{1, 0, 16'h0000, 0, 16'h0006, 1, 16'h0004, 16'h1234};
    vecs[7]  = '{1, 0, 16'h0000, 0, 16'h0006, 1, 16'h0004, 16'h1234};
    vecs[8]  = '{1, 0, 16'h0000, 0, 16'h0006, 1, 16'h0004, 16'h1234};
    vecs[9]  = '{1, 0, 16'h0000, 0, 16'h0006, 1, 16'h0004, 16'h1234};
    vecs[10] = '{1, 0, 16'h0000, 0, 16'h0006, 1, 16'h0004, 16'h1234};
    vecs[11] = '{0, 0, 16'h0000, 1, 16'h0006, 1, 16'h0004, 16'h1234};
    vecs[12] = '{0, 0, 16'h0000, 0, 16'h0006, 0, 16'h0000, 16'h0000};
    vecs[13] = '{0, 0, 16'h0000, 1, 16'h0008, 1, 16'h0006, 16'h1236};
    vecs[14] = '{0, 1, 16'h0040, 0, 16'h0008, 0, 16'h0000, 16'h0000};
    vecs[15] = '{0, 0, 16'h0000, 1, 16'h0040, 0, 16'h0000, 16'h0000};
    vecs[16] = '{0, 0, 16'h0000, 0, 16'h0040, 0, 16'h0000, 16'h0000};
    vecs[17] = '{0, 0, 16'h0000, 1, 16'h0042, 1, 16'h0040, 16'h1270};

    // Reset state while rst_n is held low
    @(negedge clk);
    #1;
    chk("rst_req", imem_bus.req, 0);
    chk("rst_addr", imem_bus.addr, 16'h0000);
    chk("rst_valid", if_valid, 0);
    chk("rst_instr", if_instr, 16'h0000);
    chk("rst_pc", if_pc, 16'h0000);
    chk("rst_inc", if_inc_pc, 16'h0000);
    chk("rst_epc", epc, 16'h0000);
    chk("rst_halted", halted, 0);

    // Streaming, stall hold, redirect racing a response (1-cycle memory)
    lat = 1;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      stall = vecs[i].stall;
      redirect = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      #1;
      $display("vec %0d req=%b addr=%h valid=%b pc=%h instr=%h", i,
               imem_bus.req, imem_bus.addr, if_valid, if_pc, if_instr);
      chk($sformatf("v%0d_req", i), imem_bus.req, vecs[i].exp_req);
      chk($sformatf("v%0d_addr", i), imem_bus.addr, vecs[i].exp_addr);
      chk($sformatf("v%0d_valid", i), if_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        chk($sformatf("v%0d_pc", i), if_pc, vecs[i].exp_pc);
        chk($sformatf("v%0d_instr", i), if_instr, vecs[i].exp_instr);
        chk($sformatf("v%0d_inc", i), if_inc_pc, vecs[i].exp_pc + 16'h0002);
      end
      @(negedge clk);
    end
    clear_inputs();

    // Squash: redirect while a 3-cycle fetch of 0x0010 is outstanding
    lat = 3;
    do_reset();
    redirect = 1; redirect_pc = 16'h0010;
    #1 chk("sq_suppress_req", imem_bus.req, 0);
    step(1); redirect = 0;
    #1 chk("sq_req10", imem_bus.req, 1);
    chk("sq_addr10", imem_bus.addr, 16'h0010);
    step(1); redirect = 1; redirect_pc = 16'h0100;
    #1 chk("sq_wait_req", imem_bus.req, 0);
    step(1); redirect = 0;
    #1 chk("sq_addr100", imem_bus.addr, 16'h0100);
    chk("sq_valid_a", if_valid, 0);
    step(1);
    #1 chk("sq_valid_b", if_valid, 0);
    chk("sq_req_b", imem_bus.req, 0);
    step(1);
    #1 chk("sq_reissue_req", imem_bus.req, 1);
    chk("sq_reissue_addr", imem_bus.addr, 16'h0100);
    chk("sq_valid_c", if_valid, 0);
    step(4);
    #1 chk("sq_fetch_valid", if_valid, 1);
    chk("sq_fetch_pc", if_pc, 16'h0100);
    chk("sq_fetch_instr", if_instr, 16'h1330);
    chk("sq_fetch_inc", if_inc_pc, 16'h0102);

    // Exception, rti 10 cycles later, then exception+redirect under stall
    lat = 1;
    do_reset();
    exception = 1; exc_pc = 16'h0044;
    #1 chk("exc_suppress_req", imem_bus.req, 0);
    step(1); exception = 0;
    #1 chk("exc_epc", epc, 16'h0044);
    chk("exc_req", imem_bus.req, 1);
    chk("exc_addr", imem_bus.addr, 16'h0002);
    step(2);
    #1 chk("exc_fetch_valid", if_valid, 1);
    chk("exc_fetch_pc", if_pc, 16'h0002);
    chk("exc_fetch_instr", if_instr, 16'h1232);
    step(7); rti = 1;
    step(1); rti = 0;
    #1 chk("rti_req", imem_bus.req, 1);
    chk("rti_addr", imem_bus.addr, 16'h0044);
    chk("rti_valid", if_valid, 0);
    step(2);
    #1 chk("rti_fetch_valid", if_valid, 1);
    chk("rti_fetch_pc", if_pc, 16'h0044);
    chk("rti_fetch_inc", if_inc_pc, 16'h0046);
    stall = 1; exception = 1; exc_pc = 16'h0088; redirect = 1; redirect_pc = 16'h0500;
    #1 chk("excbr_req", imem_bus.req, 0);
    step(1); exception = 0; redirect = 0;
    #1 chk("excbr_flush_valid", if_valid, 0);
    chk("excbr_addr", imem_bus.addr, 16'h0002);
    chk("excbr_req_free", imem_bus.req, 1);
    chk("excbr_epc", epc, 16'h0088);
    stall = 0;

    // Halt with a 3-cycle fetch outstanding, then asynchronous reset
    lat = 3;
    do_reset();
    #1 chk("halt_req0", imem_bus.req, 1);
    step(1); halt = 1;
    #1 chk("halt_pre", halted, 0);
    step(1); halt = 0;
    #1 chk("halt_halted", halted, 1);
    chk("halt_req", imem_bus.req, 0);
    chk("halt_valid", if_valid, 0);
    step(3);
    #1 chk("halt_sticky", halted, 1);
    chk("halt_req_late", imem_bus.req, 0);
    chk("halt_valid_late", if_valid, 0);
    @(posedge clk);
    #3 rst_n = 0;
    #1 chk("arst_halted", halted, 0);
    chk("arst_valid", if_valid, 0);
    chk("arst_req", imem_bus.req, 0);
    chk("arst_addr", imem_bus.addr, 16'h0000);
    step(2); rst_n = 1;
    #1 chk("arst_restart_req", imem_bus.req, 1);
    chk("arst_restart_addr", imem_bus.addr, 16'h0000);
    step(1);

    // PC wrap at 0xFFFE
    lat = 1;
    do_reset();
    redirect = 1; redirect_pc = 16'hFFFE;
    step(1); redirect = 0;
    #1 chk("wrap_addr", imem_bus.addr, 16'hFFFE);
    step(2);
    #1 chk("wrap_valid", if_valid, 1);
    chk("wrap_pc", if_pc, 16'hFFFE);
    chk("wrap_inc", if_inc_pc, 16'h0000);
    chk("wrap_instr", if_instr, 16'h122E);
    chk("wrap_next_addr", imem_bus.addr, 16'h0000);

    step(1);
    chk("single_outstanding", ovl_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
